// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, COMMIT, CSUM, DONE, ERROR
  } state_e;

  localparam int BYTES_PER_WORD  = 4;
  localparam int WORD_BYTES_LOG2 = 2;
  localparam int COUNT_W         = 16;

  // Status outputs are a pure decode of the state register.
  typedef struct packed {
    logic s_ready;
    logic cpu_hold;
    logic done;
    logic error;
  } flags_t;

  function automatic flags_t state_flags(input state_e s);
    flags_t f;
    f.s_ready  = (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CSUM);
    f.cpu_hold = (s != DONE);
    f.done     = (s == DONE);
    f.error    = (s == ERROR);
    return f;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in + instruction memory write port out.
// master: stream source / memory side, slave: the loader.
interface imem_loader_if #(
  parameter int ADDR_W = 32
);
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output s_valid, s_data,
    input  s_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_word_packer.sv
// Assembles four accepted bytes into a little-endian word.
// word_valid pulses for the cycle after the byte completing a word.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        last_lane,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [WORD_BYTES_LOG2-1:0] lane;
  // Earlier bytes shift right so lane 0 ends up in the low byte.
  logic [8*(BYTES_PER_WORD-1)-1:0] held;

  assign last_lane = (lane == WORD_BYTES_LOG2'(BYTES_PER_WORD - 1));

  // Lane counter, shift register and registered word/strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane       <= '0;
      held       <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clr) begin
        lane <= '0;
        held <= '0;
      end else if (byte_valid) begin
        if (last_lane) begin
          word       <= {byte_data, held};
          word_valid <= 1'b1;
          lane       <= '0;
        end else begin
          held <= {byte_data, held[8*(BYTES_PER_WORD-1)-1:8]};
          lane <= lane + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Program loader: length-prefixed byte stream -> instruction memory words.
// Optional trailing checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         done,
  output logic         error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e AFTER_IMAGE = CSUM;
`else
  localparam state_e AFTER_IMAGE = DONE;
`endif

  state_e             state;
  flags_t             fl;
  logic [COUNT_W-1:0] count;
  logic [COUNT_W-1:0] index;
  logic [COUNT_W-1:0] len;
  logic [ADDR_W-1:0]  addr_q;
  logic               accept;
  logic               start_ok;
  logic               pk_last;
  logic               pk_valid;
  logic [31:0]        pk_word;

  assign fl       = state_flags(state);
  assign accept   = bus.s_valid && fl.s_ready;
  assign start_ok = start && (state == IDLE || state == DONE || state == ERROR);
  assign len      = {bus.s_data, count[7:0]};

  assign bus.s_ready    = fl.s_ready;
  assign bus.imem_we    = pk_valid;
  assign bus.imem_wdata = pk_word;
  assign bus.imem_addr  = addr_q;
  assign cpu_hold       = fl.cpu_hold;
  assign done           = fl.done;
  assign error          = fl.error;

  imem_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clr        (start_ok),
    .byte_valid (accept && (state == DATA)),
    .byte_data  (bus.s_data),
    .last_lane  (pk_last),
    .word_valid (pk_valid),
    .word       (pk_word)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic       csum_ok;

  // Running mod-256 sum of every accepted byte of the current load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        sum <= '0;
    else if (start_ok) sum <= '0;
    else if (accept)   sum <= sum + bus.s_data;
  end

  // Including the checksum byte itself the total must wrap to zero.
  assign csum_ok = (8'(sum + bus.s_data) == 8'h00);
`endif

  // Load sequencer: length capture, word counting, address generation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      count  <= '0;
      index  <= '0;
      addr_q <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: if (start_ok) state <= LEN_LO;
        LEN_LO: if (accept) begin
          count[7:0] <= bus.s_data;
          state      <= LEN_HI;
        end
        LEN_HI: if (accept) begin
          count <= len;
          index <= '0;
          if (len == '0)                       state <= AFTER_IMAGE;
          else if (len > COUNT_W'(DEPTH))      state <= ERROR;
          else                                 state <= DATA;
        end
        DATA: if (accept && pk_last) begin
          addr_q <= ADDR_W'({index, 2'b00});
          index  <= index + 1'b1;
          if (index == count - 1'b1) state <= COMMIT;
        end
        // The final write strobe is visible during this cycle.
        COMMIT: state <= AFTER_IMAGE;
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: if (accept) state <= csum_ok ? DONE : ERROR;
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
